// File: rtl/nonrestoring_divider_ss.sv
// nonrestoring_divider_ss: sequential signed 2W/W non-restoring divider, one quotient bit per clock.
// Optional DIV_FAST_PATH_EN resolves D==+-1 and N==0 directly from CHECK.
module nonrestoring_divider_ss #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2*WIDTH-1:0] N,
   input  logic [WIDTH-1:0]   D,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic               overflow
);
   localparam int W = WIDTH;
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [2:0] {IDLE, CHECK, DIV, FIX, DONE} state_t;
   state_t state, state_nx;
   logic [2*W-1:0] n_r, na;
   logic [W-1:0] d_r, da, lo, q_r, qm, rm, q_fin, r_fin;
   logic [W:0] p, sh, pn;
   logic [CW-1:0] cnt;
   logic ph, dz, big, fast, neg_q, oflow;
   assign dz = d_r == '0;
   assign big = na[2*W-1:W] >= da;
`ifdef DIV_FAST_PATH_EN
   assign fast = (da == W'(1)) | (na == '0);
`else
   assign fast = 1'b0;
`endif
   assign neg_q = n_r[2*W-1] ^ d_r[W-1];
   assign sh = {p[W-1:0], lo[W-1]};
   assign pn = p[W] ? sh + {1'b0, da} : sh - {1'b0, da};
   // Fast cases finish from CHECK with |N| as the quotient magnitude and no remainder.
   assign qm = (state == CHECK) ? na[W-1:0] : q_r;
   assign rm = (state == CHECK) ? '0 : p[W] ? p[W-1:0] + da : p[W-1:0];
   assign oflow = neg_q ? qm[W-1] & |qm[W-2:0] : qm[W-1];
   assign q_fin = oflow ? '0 : neg_q ? -qm : qm;
   assign r_fin = oflow ? '0 : n_r[2*W-1] ? -rm : rm;
   assign busy = state inside {CHECK, DIV, FIX};
   assign done = state == DONE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? CHECK : IDLE;
         CHECK:   state_nx = !ph ? CHECK : (dz | big | fast) ? DONE : DIV;
         DIV:     state_nx = (cnt == CW'(W-1)) ? FIX : DIV;
         FIX:     state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {n_r, na, d_r, da, lo, q_r, p, cnt, ph} <= '0;
         {quotient, remainder, div_by_zero, overflow} <= '0;
      end else
         case (state)
            IDLE: if (start) begin
               n_r <= N;
               d_r <= D;
               ph <= 1'b0;
               div_by_zero <= 1'b0;
               overflow <= 1'b0;
            end
            CHECK: if (!ph) begin
               na <= n_r[2*W-1] ? -n_r : n_r;
               da <= d_r[W-1] ? -d_r : d_r;
               ph <= 1'b1;
            end else begin
               p <= {1'b0, na[2*W-1:W]};
               lo <= na[W-1:0];
               q_r <= '0;
               cnt <= '0;
               if (dz) begin
                  quotient <= '1;
                  remainder <= n_r[W-1:0];
                  div_by_zero <= 1'b1;
               end else if (big) begin
                  quotient <= '0;
                  remainder <= '0;
                  overflow <= 1'b1;
               end else if (fast) begin
                  quotient <= q_fin;
                  remainder <= r_fin;
                  overflow <= oflow;
               end
            end
            DIV: begin
               p <= pn;
               q_r <= {q_r[W-2:0], ~pn[W]};
               lo <= lo << 1;
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               quotient <= q_fin;
               remainder <= r_fin;
               overflow <= oflow;
            end
            default: ;
         endcase
endmodule

// File: tb/tb_nonrestoring_divider_ss.sv
// tb_nonrestoring_divider_ss: directed and random checks against a 65-bit arithmetic reference.
module tb_nonrestoring_divider_ss;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [63:0] N = '0;
   logic [31:0] D = '0;
   logic [31:0] quotient, remainder;
   logic busy, done, div_by_zero, overflow;
   int vectors = 0, miscompares = 0;
   nonrestoring_divider_ss #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .N(N), .D(D),
      .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic void model(input logic [63:0] n, input logic [31:0] d,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dz, output logic ov);
      logic signed [64:0] n65, d65, q65, r65;
      n65 = {n[63], n};
      d65 = {{33{d[31]}}, d};
      dz = d == 0;
      ov = 1'b0;
      q = '1;
      r = n[31:0];
      if (!dz) begin
         q65 = n65 / d65;
         r65 = n65 % d65;
         ov = (q65 > 65'sd2147483647) || (q65 < -65'sd2147483648);
         q = ov ? 32'd0 : q65[31:0];
         r = ov ? 32'd0 : r65[31:0];
      end
   endfunction
   task automatic run(input logic [63:0] n, input logic [31:0] d, input int lat, input string tag);
      logic [31:0] eq, er;
      logic edz, eov;
      int cyc;
      model(n, d, eq, er, edz, eov);
      @(negedge clk);
      N = n;
      D = d;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check({tag, " busy"}, busy, 1);
      cyc = 0;
      do begin
         @(posedge clk);
         #1 cyc++;
      end while (!done && cyc < 100);
      check({tag, " done"}, done, 1);
      if (lat > 0) check({tag, " latency"}, cyc, lat);
      check({tag, " busy at done"}, busy, 0);
      check({tag, " q"}, quotient, eq);
      check({tag, " r"}, remainder, er);
      check({tag, " dz"}, div_by_zero, edz);
      check({tag, " ov"}, overflow, eov);
      @(posedge clk);
      #1 check({tag, " pulse"}, done, 0);
   endtask
   initial begin
      int dones;
      logic [63:0] rn;
      logic [31:0] rd, tq, tr;
      logic tdz, tov;
      repeat (2) @(posedge clk);
      #1;
      check("reset q", quotient, 0);
      check("reset r", remainder, 0);
      check("reset flags", {busy, done, div_by_zero, overflow}, 0);
      @(negedge clk) rst_n = 1'b1;
      run(64'd83810205, 32'd12345, 35, "T1");
      run(64'd100, -32'sd7, 35, "T2a");
      run(-64'sd100, 32'd7, 35, "T2b");
      run(-64'sd100, -32'sd7, 35, "T2c");
      run(-64'sd83810205, 32'd6789, 35, "T2d");
      run(64'd5, 32'd0, 2, "T3");
      run(64'd4611686018427387904, 32'h80000000, 35, "T4a");
      run(64'd2147483648, 32'd1, 0, "T4b");
      run(64'd2147483648, -32'sd1, 0, "T4c");
      run(64'd1 << 40, 32'd2, 2, "T4d");
      run(-64'sd9223372036854775807 - 64'sd1, -32'sd1, 2, "most-neg N");
      run(64'd4294967295, 32'd1, 0, "neg-range ovf");
      run(64'd0, -32'sd9, 0, "zero N");
`ifdef DIV_FAST_PATH_EN
      run(64'd12345, -32'sd1, 2, "T6");
`else
      run(64'd12345, -32'sd1, 35, "T6");
`endif
      // Held start: one done per pass through IDLE, 37-cycle period.
      @(negedge clk);
      N = 64'd83810205;
      D = 32'd12345;
      start = 1'b1;
      @(posedge clk);
      dones = 0;
      for (int i = 1; i <= 73; i++) begin
         @(posedge clk);
         #1 if (done) dones++;
      end
      start = 1'b0;
      check("T5 held-start dones", dones, 2);
      check("T5 held-start q", quotient, 6789);
      repeat (3) @(posedge clk);
      @(negedge clk);
      N = 64'd83810205;
      D = 32'd7;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("T5 rst q", quotient, 0);
      check("T5 rst r", remainder, 0);
      check("T5 rst flags", {busy, done, div_by_zero, overflow}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 if (done) dones++;
      end
      check("T5 no done after abort", dones, 0);
      run(64'd1000, 32'd10, 35, "T5 post-reset");
      for (int i = 0; i < 1000; i++) begin
         do begin
            rn = $signed({$urandom, $urandom}) >>> $urandom_range(0, 63);
            rd = $signed($urandom) >>> $urandom_range(0, 31);
            model(rn, rd, tq, tr, tdz, tov);
         end while (tdz || tov);
         run(rn, rd, 0, "rnd");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
